// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the boot-time program loader.
//   loader_state_t : load FSM states, from length header through checksum to RUN/ERROR
//   LEN_BYTES      : bytes in the big-endian word-count header
//   CK_BYTES       : bytes in the big-endian trailing checksum
//   CK_WIDTH       : checksum / memory word width
//   takes_bytes()  : true in every state that consumes stream bytes
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CK_HI,
    ST_CK_LO,
    ST_RUN,
    ST_ERROR
  } loader_state_t;

  localparam int LEN_BYTES = 2;
  localparam int CK_BYTES  = 2;
  localparam int CK_WIDTH  = 16;

  function automatic logic takes_bytes(input loader_state_t s);
    return (s != ST_RUN) && (s != ST_ERROR);
  endfunction

endpackage

// File: rtl/byte_pair_packer.sv
// byte_pair_packer: joins a big-endian byte pair into one word.
//   clk, rst   : clock, asynchronous active-high reset
//   hi_en      : high byte of a pair accepted this cycle
//   lo_en      : low byte of a pair accepted this cycle
//   byte_in    : stream byte
//   word       : {stored high byte, current byte}, meaningful while lo_en
//   word_valid : one-cycle strobe on the low-byte accept
module byte_pair_packer
  import prog_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                hi_en,
  input  logic                lo_en,
  input  logic [7:0]          byte_in,
  output logic [CK_WIDTH-1:0] word,
  output logic                word_valid
);

  logic [7:0] hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hi_q <= '0;
    else if (hi_en)
      hi_q <= byte_in;
  end

  // The low byte is used straight from the stream so the full word is
  // available in the same cycle it is accepted.
  assign word       = {hi_q, byte_in};
  assign word_valid = lo_en;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a length-prefixed, checksummed image from a byte stream
// into the core's 16-bit memory, then releases the core and hands it the port.
//   clk, rst                       : clock, asynchronous active-high reset
//   in_valid, in_data, in_ready    : byte stream handshake
//   cpu_addr, cpu_we, cpu_wdata    : core memory port (used only in RUN)
//   mem_addr, mem_we, mem_wdata    : memory port
//   cpu_rst                        : core reset, released once the image verifies
//   done                           : image loaded and checksum matched
//   error                          : bad length or checksum mismatch
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  loader_state_t       state, next_state;
  logic                accept, hi_en, lo_en;
  logic [CK_WIDTH-1:0] word;
  logic                word_valid;
  logic [15:0]         len_q, idx_q, next_idx;
  logic [CK_WIDTH-1:0] sum_q;
  logic                wr_we_q;
  logic [15:0]         wr_addr_q, wr_data_q;

  assign in_ready = takes_bytes(state);
  assign accept   = in_valid && in_ready;
  assign hi_en    = accept && (state inside {ST_LEN_HI, ST_DATA_HI, ST_CK_HI});
  assign lo_en    = accept && (state inside {ST_LEN_LO, ST_DATA_LO, ST_CK_LO});
  assign next_idx = idx_q + 16'd1;

  // Length header, data words and checksum all share one pair packer.
  byte_pair_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .hi_en      (hi_en),
    .lo_en      (lo_en),
    .byte_in    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_LEN_HI;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (accept) begin
      unique case (state)
        ST_LEN_HI:  next_state = ST_LEN_LO;
        ST_LEN_LO: begin
          if ({1'b0, word} > MAX_N)
            next_state = ST_ERROR;
          else if (word == 16'd0)
            next_state = ST_CK_HI;
          else
            next_state = ST_DATA_HI;
        end
        ST_DATA_HI: next_state = ST_DATA_LO;
        // len_q >= 1 here, so comparing the post-increment index finds the Nth word.
        ST_DATA_LO: next_state = (next_idx == len_q) ? ST_CK_HI : ST_DATA_HI;
        ST_CK_HI:   next_state = ST_CK_LO;
        ST_CK_LO:   next_state = (word == sum_q) ? ST_RUN : ST_ERROR;
        default:    next_state = state;
      endcase
    end
  end

  // Word index, running sum and the registered write launched one cycle
  // after each data word completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      wr_we_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_we_q <= 1'b0;
      if (lo_en && state == ST_LEN_LO)
        len_q <= word;
      if (word_valid && state == ST_DATA_LO) begin
        wr_we_q   <= 1'b1;
        wr_addr_q <= BASE_ADDR + idx_q;
        wr_data_q <= word;
        idx_q     <= next_idx;
        sum_q     <= sum_q + word;
      end
    end
  end

  // The core owns the memory port only once the image has verified.
  always_comb begin
    mem_addr  = wr_addr_q;
    mem_wdata = wr_data_q;
    mem_we    = wr_we_q && (state != ST_ERROR);
    if (state == ST_RUN) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end
  end

  assign cpu_rst = (state != ST_RUN);
  assign done    = (state == ST_RUN);
  assign error   = (state == ST_ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scenario tasks driving byte-stream images into prog_loader
// and checking memory writes and final status against an image-level model.
module tb_prog_loader;

  localparam logic [15:0] BASE = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [15:0] cpu_wdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wr_log[$];
  logic [7:0]  img[$];
  logic [15:0] words[$];

  prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_wdata (cpu_wdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Record every loader write into memory (core writes in RUN excluded).
  always @(negedge clk) begin
    if (!rst && mem_we && !done)
      wr_log.push_back({mem_addr, mem_wdata});
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Image model: header N, N big-endian words, checksum ck.
  task automatic build_image(input logic [15:0] n, input logic [15:0] ck);
    img.delete();
    img.push_back(n[15:8]);
    img.push_back(n[7:0]);
    foreach (words[k]) begin
      img.push_back(words[k][15:8]);
      img.push_back(words[k][7:0]);
    end
    img.push_back(ck[15:8]);
    img.push_back(ck[7:0]);
  endtask

  function automatic logic [15:0] model_sum();
    int unsigned s = 0;
    foreach (words[k]) s = s + int'(words[k]);
    return 16'(s % 65536);
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr_log.delete();
  endtask

  // Offers img[0..count-1]; returns how many were accepted within the budget.
  // Optionally jitters cpu_we/cpu_addr, which must not reach memory outside RUN.
  task automatic send_bytes(input int count, input int gap_pct, input bit cpu_noise,
                            output int accepted);
    logic go;
    accepted = 0;
    for (int guard = 0; guard < 4000 && accepted < count; guard++) begin
      @(negedge clk);
      if (cpu_noise) begin
        cpu_we    = 1'($urandom_range(1));
        cpu_addr  = 16'($urandom);
        cpu_wdata = 16'($urandom);
      end
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = img[accepted];
      end
      go = in_valid && in_ready;
      @(posedge clk);
      if (go) accepted++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    cpu_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    cpu_we   = 1'b1;
    cpu_addr = 16'h1234;
    cpu_wdata = 16'h5678;
    #12;
    n_checks++;
    if ({in_ready, cpu_rst, done, error, mem_we} !== 5'b11000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got rdy/cpurst/done/err/we=%b expected 11000",
               {in_ready, cpu_rst, done, error, mem_we});
    end
    n_checks++;
    if ({mem_addr, mem_wdata} !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_mem_bus: got %h expected 00000000", {mem_addr, mem_wdata});
    end
    do_reset();
  endtask

  task automatic test_basic();
    int acc;
    do_reset();
    words = '{16'hC005, 16'h1000, 16'h7777};
    build_image(16'd3, 16'h477C);
    send_bytes(img.size(), 0, 1'b0, acc);
    n_checks++;
    if (acc !== img.size() || {done, cpu_rst, error, in_ready} !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL basic_status: got acc=%0d done/cpurst/err/rdy=%b expected %0d 1000",
               acc, {done, cpu_rst, error, in_ready}, img.size());
    end
    n_checks++;
    if (wr_log.size() !== 3) begin
      n_fail++;
      $display("[TB] FAIL basic_write_count: got %0d expected 3", wr_log.size());
    end
    for (int k = 0; k < wr_log.size() && k < 3; k++) begin
      n_checks++;
      if (wr_log[k] !== {BASE + 16'(k), words[k]}) begin
        n_fail++;
        $display("[TB] FAIL basic_write%0d: got %h expected %h", k, wr_log[k],
                 {BASE + 16'(k), words[k]});
      end
    end
  endtask

  task automatic test_bad_checksum();
    int acc;
    do_reset();
    words = '{16'hC005, 16'h1000, 16'h7777};
    build_image(16'd3, 16'h477D);
    send_bytes(img.size(), 0, 1'b0, acc);
    n_checks++;
    if ({error, cpu_rst, in_ready, done} !== 4'b1100) begin
      n_fail++;
      $display("[TB] FAIL badck_status: got err/cpurst/rdy/done=%b expected 1100",
               {error, cpu_rst, in_ready, done});
    end
    n_checks++;
    if (wr_log.size() !== 3) begin
      n_fail++;
      $display("[TB] FAIL badck_write_count: got %0d expected 3", wr_log.size());
    end
    for (int k = 0; k < wr_log.size() && k < 3; k++) begin
      n_checks++;
      if (wr_log[k] !== {BASE + 16'(k), words[k]}) begin
        n_fail++;
        $display("[TB] FAIL badck_write%0d: got %h expected %h", k, wr_log[k],
                 {BASE + 16'(k), words[k]});
      end
    end
    @(negedge clk);
    cpu_we = 1'b1;
    cpu_addr = 16'h0042;
    #1;
    n_checks++;
    if (mem_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL badck_cpu_we_blocked: got %b expected 0", mem_we);
    end
    cpu_we = 1'b0;
  endtask

  task automatic test_zero_len();
    int acc;
    do_reset();
    words.delete();
    build_image(16'd0, 16'h0000);
    send_bytes(img.size(), 0, 1'b0, acc);
    n_checks++;
    if ({done, cpu_rst, error} !== 3'b100 || wr_log.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL zero_len: got done/cpurst/err=%b writes=%0d expected 100 0",
               {done, cpu_rst, error}, wr_log.size());
    end
  endtask

  task automatic test_too_long();
    int acc;
    do_reset();
    img = '{8'h01, 8'h01, 8'h00, 8'h00};
    send_bytes(2, 0, 1'b0, acc);
    n_checks++;
    if ({error, cpu_rst, in_ready, done} !== 4'b1100) begin
      n_fail++;
      $display("[TB] FAIL too_long_status: got err/cpurst/rdy/done=%b expected 1100",
               {error, cpu_rst, in_ready, done});
    end
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || error !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL too_long_ignores: got rdy=%b err=%b expected 0 1", in_ready, error);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (wr_log.size() !== 0) begin
      n_fail++;
      $display("[TB] FAIL too_long_writes: got %0d expected 0", wr_log.size());
    end
  endtask

  task automatic test_gaps_and_run();
    int acc;
    logic [15:0] a, d;
    logic w;
    do_reset();
    words = '{16'hC005, 16'h1000, 16'h7777};
    build_image(16'd3, model_sum());
    send_bytes(img.size(), 40, 1'b1, acc);
    n_checks++;
    if (acc !== img.size() || {done, cpu_rst, error} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL gaps_status: got acc=%0d done/cpurst/err=%b expected %0d 100",
               acc, {done, cpu_rst, error}, img.size());
    end
    n_checks++;
    if (wr_log.size() !== 3) begin
      n_fail++;
      $display("[TB] FAIL gaps_write_count: got %0d expected 3", wr_log.size());
    end
    for (int k = 0; k < wr_log.size() && k < 3; k++) begin
      n_checks++;
      if (wr_log[k] !== {BASE + 16'(k), words[k]}) begin
        n_fail++;
        $display("[TB] FAIL gaps_write%0d: got %h expected %h", k, wr_log[k],
                 {BASE + 16'(k), words[k]});
      end
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = (i == 0) ? 16'h0042 : 16'($urandom);
      d = (i == 0) ? 16'hBEEF : 16'($urandom);
      w = (i == 0) ? 1'b1 : 1'($urandom_range(1));
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_we    = w;
      in_valid  = 1'b1;
      in_data   = 8'($urandom);
      #1;
      n_checks++;
      if ({mem_addr, mem_wdata, mem_we} !== {a, d, w}) begin
        n_fail++;
        $display("[TB] FAIL run_passthrough%0d: got %h/%h/%b expected %h/%h/%b", i,
                 mem_addr, mem_wdata, mem_we, a, d, w);
      end
      n_checks++;
      if ({in_ready, done, cpu_rst, error} !== 4'b0100) begin
        n_fail++;
        $display("[TB] FAIL run_ignores_stream%0d: got rdy/done/cpurst/err=%b expected 0100",
                 i, {in_ready, done, cpu_rst, error});
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    cpu_we   = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    int acc;
    do_reset();
    words = '{16'hC005, 16'h1000, 16'h7777};
    build_image(16'd3, 16'h477C);
    send_bytes(6, 0, 1'b0, acc);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_we, cpu_rst, in_ready, done} !== 4'b0110) begin
      n_fail++;
      $display("[TB] FAIL midrst_abort: got we/cpurst/rdy/done=%b expected 0110",
               {mem_we, cpu_rst, in_ready, done});
    end
    n_checks++;
    if (wr_log.size() !== 2) begin
      n_fail++;
      $display("[TB] FAIL midrst_write_count: got %0d expected 2", wr_log.size());
    end
    @(negedge clk);
    rst = 1'b0;
    wr_log.delete();
    send_bytes(img.size(), 0, 1'b0, acc);
    n_checks++;
    if ({done, cpu_rst, error} !== 3'b100 || wr_log.size() !== 3) begin
      n_fail++;
      $display("[TB] FAIL midrst_reload: got done/cpurst/err=%b writes=%0d expected 100 3",
               {done, cpu_rst, error}, wr_log.size());
    end
    for (int k = 0; k < wr_log.size() && k < 3; k++) begin
      n_checks++;
      if (wr_log[k] !== {BASE + 16'(k), words[k]}) begin
        n_fail++;
        $display("[TB] FAIL midrst_write%0d: got %h expected %h", k, wr_log[k],
                 {BASE + 16'(k), words[k]});
      end
    end
  endtask

  // Random images, including the largest legal length and oversize headers.
  task automatic test_random_images();
    int          acc, n, nsend, exp_n;
    logic [15:0] ck;
    bit          exp_ok;
    for (int it = 0; it < 10; it++) begin
      do_reset();
      words.delete();
      if (it == 0)      n = 256;
      else if (it == 1) n = 257 + $urandom_range(0, 200);
      else              n = $urandom_range(0, 7);
      if (n <= 256)
        for (int k = 0; k < n; k++) words.push_back(16'($urandom));
      ck = model_sum();
      if (it > 1 && $urandom_range(2) == 0) ck = ck ^ 16'(1 << $urandom_range(15));
      build_image(16'(n), ck);
      exp_ok = (n <= 256) && (ck == model_sum());
      exp_n  = (n <= 256) ? n : 0;
      nsend  = (n <= 256) ? img.size() : 2;
      send_bytes(nsend, (it == 0) ? 0 : 30, 1'b1, acc);
      n_checks++;
      if (acc !== nsend || {done, cpu_rst, error, in_ready} !== {exp_ok, !exp_ok, !exp_ok, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_status: got acc=%0d done/cpurst/err/rdy=%b expected %0d %b",
                 it, acc, {done, cpu_rst, error, in_ready}, nsend,
                 {exp_ok, !exp_ok, !exp_ok, 1'b0});
      end
      n_checks++;
      if (wr_log.size() !== exp_n) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_write_count: got %0d expected %0d", it, wr_log.size(), exp_n);
      end
      for (int k = 0; k < wr_log.size() && k < exp_n; k++) begin
        n_checks++;
        if (wr_log[k] !== {BASE + 16'(k), words[k]}) begin
          n_fail++;
          $display("[TB] FAIL rand%0d_write%0d: got %h expected %h", it, k, wr_log[k],
                   {BASE + 16'(k), words[k]});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_checksum();
    test_zero_len();
    test_too_long();
    test_gaps_and_run();
    test_reset_mid_load();
    test_random_images();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader upstream of the proc core and its 16-bit unified memory.
- Takes a byte stream (valid/ready), packs bytes into 16-bit instruction words, writes them into memory and checks a trailing checksum.
- Holds the core in reset until a good image is loaded, then hands the memory port to the core.

Parameters:
- BASE_ADDR, 16'h0000, memory address of the first loaded word.
- MAX_WORDS, 256, largest accepted word count; matches the core's 8-bit pc range.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  byte stream valid
- in_data  input  8  byte stream data
- in_ready  output  1  loader accepts a byte this cycle
- cpu_addr  input  16  core memory address
- cpu_we  input  1  core write enable
- cpu_wdata  input  16  core write data
- mem_addr  output  16  to memory
- mem_we  output  1  to memory
- mem_wdata  output  16  to memory
- cpu_rst  output  1  active-high reset to core
- done  output  1  image loaded and verified
- error  output  1  load failed

Behaviour:
- Image format, all fields big-endian (high byte first):
  - N: 2-byte word count.
  - Data: N words.
  - Checksum: 2 bytes, equal to the sum of all data words mod 2^16.
- A byte is accepted on a rising clk edge when in_valid && in_ready. in_ready is decoded from state: 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CK_HI, CK_LO; 0 in RUN and ERROR.
- States and transitions (each byte-consuming transition only on accept):
  - LEN_HI -> LEN_LO.
  - LEN_LO: if N > MAX_WORDS -> ERROR; else if N == 0 -> CK_HI; else -> DATA_HI.
  - DATA_HI -> DATA_LO.
  - DATA_LO: -> DATA_HI if words remain after this one; -> CK_HI after the Nth word.
  - CK_HI -> CK_LO.
  - CK_LO: -> RUN if checksum matches; else -> ERROR.
  - RUN and ERROR are terminal until rst.
- Write path, registered:
  - The cycle after the DATA_LO byte is accepted, mem_we=1 for exactly one cycle, with mem_addr = BASE_ADDR + word index and mem_wdata = {hi, lo}.
  - Word index starts at 0 and increments per word; 16-bit adds wrap.
  - No stall: back-to-back bytes at full rate are supported.
- Running sum: a 16-bit accumulator adds each word when DATA_LO is accepted; carries are dropped. It is compared with the checksum on CK_LO accept.
- RUN:
  - mem_addr, mem_we and mem_wdata are combinational passthrough of cpu_addr, cpu_we and cpu_wdata.
  - cpu_rst=0 and done=1, both registered, from the cycle after the CK_LO accept.
  - in_valid is ignored.
- ERROR: error=1, cpu_rst=1, done=0, mem_we=0, in_ready=0.
- Reset values (asynchronous):
  - state=LEN_HI, so in_ready decodes to 1 while rst is high; no byte is accepted until rst is low.
  - cpu_rst=1, done=0, error=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Counters and accumulator cleared.
- Reset mid-load: abort immediately; no further mem_we. Words already written stay in memory. The next image starts at LEN_HI.
- Outside RUN, cpu_we has no effect on memory.

Decomposition:
- Package prog_loader_pkg:
  - loader_state_t enum.
  - LEN_BYTES=2 and CK_BYTES=2 constants.
  - Checksum width constant (16).
- One natural sub-module: byte_pair_packer.
  - Holds the high-byte register.
  - Emits a {hi, lo} word plus a one-cycle word_valid on the low-byte accept.
  - Word index, accumulator and mux stay in the top module.

Test Plan:
- Stream 00 03 C0 05 10 00 77 77 47 7C at full rate -> mem_we pulses with (0x0000, 0xC005), (0x0001, 0x1000), (0x0002, 0x7777); cpu_rst falls and done=1 the cycle after the last byte.
- Same stream with checksum 47 7D -> the three writes still occur; then error=1, cpu_rst stays 1, in_ready=0, done=0.
- Stream 00 00 00 00 -> no mem_we; done=1, cpu_rst=0.
- Stream 01 01 (N=257) -> error=1 the cycle after the second byte; no mem_we; further bytes not accepted.
- Test-1 stream with in_valid dropped on random cycles -> identical writes and result. Then in RUN drive cpu_addr=0x0042, cpu_we=1, cpu_wdata=0xBEEF -> same-cycle mem outputs equal these; in_valid bytes are ignored.
- Assert rst after two words of the test-1 stream -> mem_we=0 immediately, cpu_rst=1, state LEN_HI. A fresh full test-1 stream then loads successfully.
